wand_bus_sched: RTL

Round-robin scheduler that shares one 8-bit wired-AND output net (packed `[1:1][2:3][4:4][1:4]`) between `N` requesters. It grants exclusive drive rights for bursts of up to `MAX_BEATS` beats. Granted data is registered onto the net, and the net is held at the wand-neutral value (all ones) at all other times, so no requester ever contends on the net. It sits between per-requester producers and the multi-driven `wand` output port.

---
 rtl/wand_bus_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/wand_bus_sched.sv
// wand_bus_sched: round-robin scheduler that gives N requesters bursts of up
// to MAX_BEATS beats on a shared 8-bit wired-AND net. Beat data is registered
// onto bus_drv. At all other times the net is held at all ones, the
// wand-neutral value.
// Optional feature: define WSCHED_TIMEOUT_EN to abort a grant after TIMEOUT
// consecutive idle XFER cycles.
module wand_bus_sched #(
    parameter int N         = 4,
    parameter int MAX_BEATS = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             req,
    input  logic [N-1:0]             valid,
    input  logic [N-1:0]             last,
    input  logic [N*8-1:0]           data,
    output logic [N-1:0]             ready,
    output logic [N-1:0]             gnt,
    output logic [1:1][2:3][4:4][1:4] bus_drv,
    output logic                     bus_oe,
    output logic                     busy,
    output logic                     abort
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_TURN = 2'd2;

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_BEATS + 1);

    logic [1:0]    r_state;
    logic [N-1:0]  r_gnt;
    logic [PW-1:0] r_gidx;
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_beat_cnt;
    logic [7:0]    r_bus_drv;
    logic          r_bus_oe;

    logic [PW-1:0] w_win_idx;
    logic [N-1:0]  w_win_oh;
    logic          w_found;
    logic [PW-1:0] w_ptr_nxt;
    logic [7:0]    w_gdata;
    logic          w_in_xfer;
    logic          w_beat;
    logic          w_cnt_hit;
    logic          w_tmo;
    logic          w_exit;

    assign w_in_xfer = (r_state == S_XFER);
    assign w_gdata   = data[8*int'(r_gidx) +: 8];
    assign w_beat    = w_in_xfer & valid[r_gidx];
    assign w_cnt_hit = (r_beat_cnt == CW'(MAX_BEATS - 1));
    assign w_ptr_nxt = (int'(r_gidx) == N - 1) ? '0 : r_gidx + 1'b1;
    // A timeout can only fire on a non-beat cycle, so a beat always wins.
    assign w_exit    = w_in_xfer & (w_beat ? (last[r_gidx] | w_cnt_hit)
                                           : (~req[r_gidx] | w_tmo));

    assign ready   = w_in_xfer ? r_gnt : '0;
    assign gnt     = r_gnt;
    assign bus_drv = r_bus_drv;
    assign bus_oe  = r_bus_oe;
    assign busy    = (r_state != S_IDLE);

    // Winner: first set req bit at or above ptr, searching upward with wrap.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_win_oh  = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % N]) begin
                w_found   = 1'b1;
                w_win_idx = PW'((int'(r_ptr) + k) % N);
            end
        end
        w_win_oh[w_win_idx] = 1'b1;
    end

    // Main FSM: grant, beat transfer onto the net, and the one-cycle turnaround.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_gidx     <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
            r_bus_drv  <= 8'hFF;
            r_bus_oe   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_bus_drv <= 8'hFF;
                    r_bus_oe  <= 1'b0;
                    if (|req) begin
                        r_state <= S_XFER;
                        r_gnt   <= w_win_oh;
                        r_gidx  <= w_win_idx;
                    end
                end
                S_XFER: begin
                    r_bus_oe  <= w_beat;
                    r_bus_drv <= w_beat ? w_gdata : 8'hFF;
                    if (w_beat)
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    if (w_exit) begin
                        r_state    <= S_TURN;
                        r_gnt      <= '0;
                        r_beat_cnt <= '0;
                        r_ptr      <= w_ptr_nxt;
                    end
                end
                S_TURN: begin
                    r_bus_drv <= 8'hFF;
                    r_bus_oe  <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef WSCHED_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] r_idle_cnt;
    logic          r_abort;

    assign w_tmo = w_in_xfer & ~w_beat & (r_idle_cnt == IW'(TIMEOUT - 1));
    assign abort = r_abort;

    // Idle counter: consecutive non-beat XFER cycles; abort pulses with TURN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_abort <= w_tmo;
            if (!w_in_xfer || w_beat || w_exit)
                r_idle_cnt <= '0;
            else
                r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
    assign abort = 1'b0;
`endif

endmodule
